// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
// State encoding, length codes and the IO window base.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd3;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    // Byte count for a length code; the unused code 2 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_byte_pack.sv
// Little-endian reassembly register for byte-serial reads.
// packed_o already includes the byte captured this cycle.
module mem_byte_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cap,
    input  logic [1:0]  slot,
    input  logic [7:0]  din,
    output logic [31:0] packed_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    // Clear on a new access so bytes above the length read back as zero.
    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (cap) begin
            word_d[{slot, 3'b000} +: 8] = din;
        end
    end

    // Packed word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign packed_o = word_d;

endmodule

// File: rtl/mem_arbiter.sv
// Sole owner of the byte-wide memory bus: arbitrates fetch and
// load/store requests and serialises them into byte transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_busy,
    output logic              mem_busy,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                ram_wr_q, ram_wr_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

    logic                pack_clr;
    logic                pack_cap;
    logic [31:0]         packed_w;
    logic [ADDR_W-1:0]   next_a;

    assign next_a = addr_q + ADDR_W'(idx_q);

    mem_byte_pack u_pack (
        .clk      (clk),
        .rst      (rst),
        .clr      (pack_clr),
        .cap      (pack_cap),
        .slot     (idx_q[1:0] - 2'd1),
        .din      (ram_din),
        .packed_o (packed_w)
    );

    // Next-state, bus issue and completion; nothing moves while rdy is low.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        n_d         = n_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        pack_clr    = 1'b0;
        pack_cap    = 1'b0;
        if (rdy) begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_req || if_req) begin
                        owner_d  = mem_req;
                        we_d     = mem_req & mem_we;
                        addr_d   = mem_req ? mem_addr : if_addr;
                        n_d      = mem_req ? len_bytes(mem_len) : 3'd4;
                        wdata_d  = mem_wdata;
                        idx_d    = 3'd1;
                        pack_clr = 1'b1;
                        ram_a_d  = addr_d;
                        if (we_d) begin
                            ram_dout_d = mem_wdata[7:0];
                            ram_wr_d   = 1'b1;
                            state_d    = S_WRITE;
                        end else begin
                            state_d = S_READ;
                        end
                    end
                end
                S_READ: begin
                    pack_cap = 1'b1;
                    if (idx_q < n_q) begin
                        ram_a_d = next_a;
                        idx_d   = idx_q + 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_WRITE: begin
                    if (idx_q < n_q) begin
                        ram_a_d    = next_a;
                        ram_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                        ram_wr_d   = 1'b1;
                        idx_d      = idx_q + 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
            endcase
            if (state_d == S_DONE && state_q != S_DONE) begin
                if (owner_q) begin
                    mem_done_d = 1'b1;
                    if (!we_q) begin
                        mem_rdata_d = DATA_W'(packed_w);
                    end
                end else begin
                    if_done_d = 1'b1;
                    if_data_d = DATA_W'(packed_w);
                end
            end
        end
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_busy   = if_req & ~if_done_q;
    assign mem_busy  = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, reference memory image,
// expected-write queue and per-cycle protocol checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_len = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        if_busy;
    logic        mem_busy;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    int tests = 0;
    int fails = 0;
    int io_cnt = 0;

    logic [7:0]  ram [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        poke_en = 1'b0;
    logic [39:0] wq [$];
    logic        force_low = 1'b0;
    logic        rand_en = 1'b0;
    logic        started = 1'b0;

    logic        rdy_e, rst_e, wr_e;
    logic [31:0] a_e;
    logic [7:0]  d_e;
    logic        prev_if_done = 1'b0, prev_mem_done = 1'b0;
    logic [31:0] last_a = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .if_busy(if_busy), .mem_busy(mem_busy),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_a(ram_a), .ram_wr(ram_wr)
    );

    // Byte RAM: address registered at one edge, data returned next cycle.
    always @(posedge clk) begin
        if (poke_en) begin
            for (int i = 0; i < 1024; i++) ram[i] <= ref_mem[i];
        end else if (ram_wr) begin
            ram[ram_a[9:0]] <= ram_dout;
        end
    end
    assign ram_din = ram[ram_a[9:0]];

    always @(negedge clk) begin
        rdy = !force_low && (!rand_en || ($urandom_range(0, 3) != 0));
    end

    always @(posedge clk) begin
        rdy_e = rdy;
        rst_e = rst;
        wr_e  = ram_wr;
        a_e   = ram_a;
        d_e   = ram_dout;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ref_mem[a[9:0]];
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    // Per-cycle protocol checks.
    always @(negedge clk) begin
        if (started) begin
            check("if_busy", if_busy, if_req & ~if_done);
            check("mem_busy", mem_busy, mem_req & ~mem_done);
            check("one_done", if_done & mem_done, 1'b0);
            check("done_pulse",
                  (if_done & prev_if_done) | (mem_done & prev_mem_done), 1'b0);
            if (ram_wr) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: a=%h d=%h required none",
                             ram_a, ram_dout);
                end else begin
                    check("write_byte", {ram_a, ram_dout}, wq.pop_front());
                end
            end
            if (!rdy_e && !rst_e) begin
                check("freeze_a", ram_a, a_e);
                check("freeze_dout", ram_dout, d_e);
                check("freeze_wr", ram_wr, 1'b0);
            end
            if (ram_a == IO_BASE && last_a != IO_BASE) io_cnt++;
        end
        prev_if_done  = if_done;
        prev_mem_done = mem_done;
        last_a        = ram_a;
    end

    task automatic mem_op(input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, output logic [31:0] data,
                          output longint t);
        int n;
        int cnt;
        logic [31:0] a;
        logic [31:0] exp;
        n = nbytes(len);
        if (we) begin
            for (int i = 0; i < n; i++) begin
                a = addr + i;
                wq.push_back({a, wd[8*i +: 8]});
                ref_mem[a[9:0]] = wd[8*i +: 8];
            end
        end
        mem_we    = we;
        mem_len   = len;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_req   = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!mem_done && cnt < 300);
        t = $time;
        data = mem_rdata;
        if (!mem_done) begin
            tests++;
            fails++;
            $display("FAIL mem_timeout: no mem_done after %0d cycles", cnt);
        end else begin
            if (!we) begin
                exp = '0;
                for (int i = 0; i < n; i++) exp[8*i +: 8] = rb(addr + i);
                check("mem_rdata", mem_rdata, exp);
            end
            if (exp_lat >= 0) check("mem_lat", cnt, exp_lat);
        end
        mem_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic if_op(input logic [31:0] addr, input int exp_lat,
                         output logic [31:0] data, output longint t);
        int cnt;
        logic [31:0] exp;
        if_addr = addr;
        if_req  = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!if_done && cnt < 300);
        t = $time;
        data = if_data;
        if (!if_done) begin
            tests++;
            fails++;
            $display("FAIL if_timeout: no if_done after %0d cycles", cnt);
        end else begin
            exp = {rb(addr + 3), rb(addr + 2), rb(addr + 1), rb(addr)};
            check("if_data", if_data, exp);
            if (exp_lat >= 0) check("if_lat", cnt, exp_lat);
        end
        if_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, d2;
        longint tm, ti;
        int io0, n;
        int kind;
        bit we;
        logic [1:0] len;
        logic [31:0] a, wd, fa;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        ref_mem[10'h100] = 8'h11;
        ref_mem[10'h101] = 8'h22;
        ref_mem[10'h102] = 8'h33;
        ref_mem[10'h103] = 8'h44;
        ref_mem[10'h000] = 8'h41;

        rst = 1'b1;
        poke_en = 1'b1;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ram_a", ram_a, 32'h0);
        check("rst_ram_dout", ram_dout, 8'h0);
        check("rst_ram_wr", ram_wr, 1'b0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_mem_done", mem_done, 1'b0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        rst = 1'b0;
        started = 1'b1;

        if_op(32'h100, 5, d, ti);
        check("fetch_word", d, 32'h4433_2211);

        mem_op(1'b1, LEN_W, 32'h200, 32'hDEAD_BEEF, 5, d, tm);
        check("store_word",
              {ram[10'h203], ram[10'h202], ram[10'h201], ram[10'h200]},
              32'hDEAD_BEEF);

        io0 = io_cnt;
        fork
            mem_op(1'b0, LEN_B, IO_BASE, 32'h0, 2, d, tm);
            if_op(32'h100, 8, d2, ti);
        join
        check("io_rdata", d, 32'h0000_0041);
        check("io_once", io_cnt - io0, 1);
        check("arb_order", tm < ti, 1'b1);
        check("arb_fetch", d2, 32'h4433_2211);

        fork
            if_op(32'h100, 8, d, ti);
            begin
                repeat (2) @(posedge clk);
                #2 force_low = 1'b1;
                repeat (3) @(posedge clk);
                #2 force_low = 1'b0;
            end
        join
        check("stall_fetch", d, 32'h4433_2211);

        fork
            mem_op(1'b1, LEN_H, 32'h300, 32'h0000_A5C3, 5, d, tm);
            begin
                repeat (1) @(posedge clk);
                #2 force_low = 1'b1;
                repeat (2) @(posedge clk);
                #2 force_low = 1'b0;
            end
        join
        check("stall_store", {ram[10'h301], ram[10'h300]}, 16'hA5C3);

        mem_op(1'b0, 2'd2, 32'h200, 32'h0, 5, d, tm);
        check("len2_as_word", d, 32'hDEAD_BEEF);

        wq.push_back({32'h340, 8'h0D});
        wq.push_back({32'h341, 8'hF0});
        ref_mem[10'h340] = 8'h0D;
        ref_mem[10'h341] = 8'hF0;
        mem_we    = 1'b1;
        mem_len   = LEN_W;
        mem_addr  = 32'h340;
        mem_wdata = 32'h0BAD_F00D;
        mem_req   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mem_req = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_wr", ram_wr, 1'b0);
        check("rstmid_done", mem_done, 1'b0);
        check("rstmid_a", ram_a, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_nodone", mem_done, 1'b0);
        check("rstmid_ram",
              {ram[10'h342], ram[10'h341], ram[10'h340]},
              {ref_mem[10'h342], 16'hF00D});
        if_op(32'h100, 5, d, ti);
        check("after_rst_fetch", d, 32'h4433_2211);

        mem_op(1'b1, LEN_H, 32'hFFFF_FFFF, 32'h0000_7788, 3, d, tm);
        mem_op(1'b0, LEN_H, 32'hFFFF_FFFF, 32'h0, 3, d, tm);
        check("wrap_load", d, 32'h0000_7788);

        for (int k = 0; k < 120; k++) begin
            if (k == 60) rand_en = 1'b1;
            kind = $urandom_range(0, 2);
            we   = 1'($urandom_range(0, 1));
            len  = 2'($urandom_range(0, 3));
            a    = $urandom;
            wd   = $urandom;
            fa   = $urandom;
            n    = nbytes(len);
            if (kind == 0) begin
                mem_op(we, len, a, wd, rand_en ? -1 : n + 1, d, tm);
            end else if (kind == 1) begin
                if_op(fa, rand_en ? -1 : 5, d, ti);
            end else begin
                fork
                    mem_op(we, len, a, wd, rand_en ? -1 : n + 1, d, tm);
                    if_op(fa, rand_en ? -1 : n + 7, d2, ti);
                join
                check("rand_order", tm < ti, 1'b1);
            end
        end
        rand_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("writes_drained", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
